pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards
//  between FD and DX. Sequences the multi-cycle multdiv unit for mul/div in DX:
//  start pulse, pipeline freeze, result hand-off, watchdog. Applies branch/jump flushes.
//  Drives the PC/FD/DX latch enables and the bubble-insert controls.
// PARAMETERS
//  MD_TIMEOUT  64     max BUSY cycles before watchdog abort (>=2)
//  CNT_W       7      watchdog counter width; must hold MD_TIMEOUT
//  MUL_ALUOP   5'd6   ALU_op field [6:2] of mul (opcode 0)
//  DIV_ALUOP   5'd7   ALU_op field [6:2] of div (opcode 0)
// PORTS
//  clock             in   1   rising-edge clock
//  reset             in   1   asynchronous, active-high reset
//  FD_Latch_Instr    in   32  instruction in FD latch
//  DX_Latch_Instr    in   32  instruction in DX latch
//  branch_taken      in   1   X stage redirects PC (bne/blt taken, j, jal, jr, bex taken)
//  md_resultRDY      in   1   multdiv result valid (single-cycle pulse)
//  md_exception_in   in   1   multdiv overflow/div-by-zero, qualified by md_resultRDY
//  pc_enable         out  1   PC register write enable
//  FD_enable         out  1   FD latch write enable
//  DX_enable         out  1   DX latch write enable
//  FD_flush          out  1   load nop into FD
//  DX_insert_nop     out  1   load nop into DX instead of FD contents
//  XM_insert_nop     out  1   load nop into XM instead of DX results
//  ctrl_MULT         out  1   registered one-cycle multdiv start, multiply
//  ctrl_DIV          out  1   registered one-cycle multdiv start, divide
//  md_result_select  out  1   XM takes multdiv result instead of ALU output
//  md_exception      out  1   write rstatus (r30) with the mul/div exception code
//  md_timeout        out  1   watchdog fired (sticky until next mul/div start)
// BEHAVIOUR
//  Fields: opcode[31:27] rd[26:22] rs[21:17] rt[16:12] ALU_op[6:2].
//  During reset: state=IDLE, counter=0, all enables=1, all other outputs=0.
//  FSM IDLE/BUSY/DONE. Priority: reset > multdiv FSM > branch flush > load-use.
//  IDLE, DX is mul/div (op 0, ALU_op MUL/DIV):
//    - Combinational freeze: pc/FD/DX enable=0, XM_insert_nop=1.
//    - Next state BUSY.
//    - ctrl_MULT or ctrl_DIV =1 for exactly the first BUSY cycle.
//  BUSY:
//    - Freeze held; counter +1 per cycle.
//    - md_resultRDY -> DONE.
//    - counter==MD_TIMEOUT-1 without RDY -> DONE with forced exception; md_timeout set.
//    - RDY on the timeout cycle counts as a normal completion.
//  DONE (1 cycle):
//    - All enables=1, XM_insert_nop=0, md_result_select=1.
//    - md_exception=latched md_exception_in | timeout.
//    - Next IDLE. The mul/div still in DX must not retrigger.
//    - FD->DX load-use check still applies this cycle.
//  branch_taken in IDLE: FD_flush=1, DX_insert_nop=1; pc/FD/DX enables stay 1.
//  branch_taken in BUSY/DONE: illegal, ignored (assertion).
//  Load-use (IDLE, no branch):
//    - Condition: DX opcode 8 (lw), DX rd!=0, and FD reads DX rd.
//    - FD reads per type:
//        op0 (rs, rt)
//        op5/op8 (rs)
//        op7 sw (rd, rs)
//        op2/op6 (rd, rs)
//        op4 (rd)
//        op22 bex (r30)
//    - Response: pc_enable=0, FD_enable=0, DX_insert_nop=1. One bubble per lw.
//  Counter: zeroed on entering BUSY. No wrap; saturates at MD_TIMEOUT-1.
//  Async reset mid-BUSY: immediate IDLE, ctrl pulses dropped, md_timeout cleared.
// TESTING
//  1. lw r5 in DX, FD add r6,r5,r2 -> one cycle: pc_enable=0, FD_enable=0, DX_insert_nop=1; then all enables 1.
//  2. mul in DX; md_resultRDY on the 5th BUSY cycle:
//       -> ctrl_MULT=1 in cycle 1 only; freeze for 6 cycles; DONE with md_result_select=1; no retrigger.
//  3. div, RDY+md_exception_in together -> DONE with md_exception=1, md_timeout=0.
//  4. mul, RDY never, MD_TIMEOUT=8 -> DONE after 8 BUSY cycles; md_exception=1, md_timeout=1.
//  5. branch_taken with lw hazard pending -> FD_flush=1, DX_insert_nop=1, pc_enable=1.
//  6. reset pulsed on BUSY cycle 3 -> state IDLE and outputs at reset values immediately; no stray ctrl_DIV.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//   Central stall/flush sequencer for the 5-stage pipeline.
//   - Load-use hazard detection between the FD and DX latches (one bubble per lw).
//   - Multi-cycle multdiv sequencing for mul/div sitting in DX: registered
//     start pulse, pipeline freeze, result hand-off, watchdog abort.
//   - Branch/jump flushes from the X stage.
//
// Ports
//   clock             in   rising-edge clock
//   reset             in   asynchronous, active-high reset
//   FD_Latch_Instr    in   [31:0] instruction in FD latch
//   DX_Latch_Instr    in   [31:0] instruction in DX latch
//   branch_taken      in   X stage redirects PC
//   md_resultRDY      in   multdiv result valid (single-cycle pulse)
//   md_exception_in   in   multdiv overflow/div-by-zero, qualified by md_resultRDY
//   pc_enable         out  PC register write enable
//   FD_enable         out  FD latch write enable
//   DX_enable         out  DX latch write enable
//   FD_flush          out  load nop into FD
//   DX_insert_nop     out  load nop into DX instead of FD contents
//   XM_insert_nop     out  load nop into XM instead of DX results
//   ctrl_MULT         out  registered one-cycle multdiv start, multiply
//   ctrl_DIV          out  registered one-cycle multdiv start, divide
//   md_result_select  out  XM takes multdiv result instead of ALU output
//   md_exception      out  write rstatus (r30) with the mul/div exception code
//   md_timeout        out  watchdog fired (sticky until next mul/div start)
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int         MD_TIMEOUT = 64,
    parameter int         CNT_W      = 7,
    parameter logic [4:0] MUL_ALUOP  = 5'd6,
    parameter logic [4:0] DIV_ALUOP  = 5'd7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FD_Latch_Instr,
    input  logic [31:0] DX_Latch_Instr,
    input  logic        branch_taken,
    input  logic        md_resultRDY,
    input  logic        md_exception_in,
    output logic        pc_enable,
    output logic        FD_enable,
    output logic        DX_enable,
    output logic        FD_flush,
    output logic        DX_insert_nop,
    output logic        XM_insert_nop,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        md_result_select,
    output logic        md_exception,
    output logic        md_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             exc_q;      // md_exception_in captured with the result
    logic             lu_q;       // a load-use bubble was inserted last cycle

    // Instruction fields
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    assign dx_op  = DX_Latch_Instr[31:27];
    assign dx_rd  = DX_Latch_Instr[26:22];
    assign dx_alu = DX_Latch_Instr[6:2];
    assign fd_op  = FD_Latch_Instr[31:27];
    assign fd_rd  = FD_Latch_Instr[26:22];
    assign fd_rs  = FD_Latch_Instr[21:17];
    assign fd_rt  = FD_Latch_Instr[16:12];

    logic unused_bits;
    assign unused_bits = ^{DX_Latch_Instr[21:7], DX_Latch_Instr[1:0], FD_Latch_Instr[11:0]};

    logic dx_is_mul, dx_is_div, dx_is_md, md_start, md_finish;
    assign dx_is_mul = (dx_op == 5'd0) && (dx_alu == MUL_ALUOP);
    assign dx_is_div = (dx_op == 5'd0) && (dx_alu == DIV_ALUOP);
    assign dx_is_md  = dx_is_mul || dx_is_div;
    assign md_start  = (state == IDLE) && dx_is_md;
    // RDY on the final watchdog cycle still counts as a normal completion.
    assign md_finish = (state == BUSY) && (md_resultRDY || (cnt == CNT_LAST));

    // Does the FD instruction read the register the DX lw is writing?
    logic fd_reads_dx_rd;
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        fd_reads_dx_rd = 1'b0;
        case (fd_op)
            5'd0:        fd_reads_dx_rd = (fd_rs == dx_rd) || (fd_rt == dx_rd);
            5'd5, 5'd8:  fd_reads_dx_rd = (fd_rs == dx_rd);
            5'd2, 5'd6,
            5'd7:        fd_reads_dx_rd = (fd_rd == dx_rd) || (fd_rs == dx_rd);
            5'd4:        fd_reads_dx_rd = (fd_rd == dx_rd);
            5'd22:       fd_reads_dx_rd = (dx_rd == 5'd30);
            default:     fd_reads_dx_rd = 1'b0;
        endcase
    end

    // lu_q limits the response to a single bubble per lw, even if DX is not refreshed.
    logic lu_hazard;
    assign lu_hazard = (dx_op == 5'd8) && (dx_rd != 5'd0) && fd_reads_dx_rd && !lu_q;

    // Next state and outputs
    always_comb begin
        state_nxt        = state;
        pc_enable        = 1'b1;
        FD_enable        = 1'b1;
        DX_enable        = 1'b1;
        FD_flush         = 1'b0;
        DX_insert_nop    = 1'b0;
        XM_insert_nop    = 1'b0;
        md_result_select = 1'b0;
        md_exception     = 1'b0;
        // Outputs are forced to their idle values while reset is held, whatever DX holds.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (dx_is_md) begin
                        state_nxt     = BUSY;
                        pc_enable     = 1'b0;
                        FD_enable     = 1'b0;
                        DX_enable     = 1'b0;
                        XM_insert_nop = 1'b1;
                    end else if (branch_taken) begin
                        FD_flush      = 1'b1;
                        DX_insert_nop = 1'b1;
                    end else if (lu_hazard) begin
                        pc_enable     = 1'b0;
                        FD_enable     = 1'b0;
                        DX_insert_nop = 1'b1;
                    end
                end
                BUSY: begin
                    if (md_finish) state_nxt = DONE;
                    pc_enable     = 1'b0;
                    FD_enable     = 1'b0;
                    DX_enable     = 1'b0;
                    XM_insert_nop = 1'b1;
                end
                DONE: begin
                    // The mul/div still in DX is not re-examined here.
                    state_nxt        = IDLE;
                    md_result_select = 1'b1;
                    md_exception     = exc_q || md_timeout;
                    if (lu_hazard) begin
                        pc_enable     = 1'b0;
                        FD_enable     = 1'b0;
                        DX_insert_nop = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic lu_stall;
    assign lu_stall = DX_insert_nop && !FD_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            exc_q      <= 1'b0;
            lu_q       <= 1'b0;
            ctrl_MULT  <= 1'b0;
            ctrl_DIV   <= 1'b0;
            md_timeout <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state     <= state_nxt;
            lu_q      <= lu_stall;
            ctrl_MULT <= md_start && dx_is_mul;
            ctrl_DIV  <= md_start && dx_is_div;
            if (md_start) begin
                cnt        <= '0;
                exc_q      <= 1'b0;
                md_timeout <= 1'b0;
            end else if (state == BUSY) begin
                if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
                if (md_finish) begin
                    exc_q      <= md_resultRDY && md_exception_in;
                    md_timeout <= !md_resultRDY;
                end
            end
        end
    end

    // A redirect while the multdiv unit owns the pipeline is a sequencing error upstream.
    a_no_branch_during_md : assert property (
        @(posedge clock) disable iff (reset) (state != IDLE) |-> !branch_taken
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//   Directed bench for pipeline_stall_controller (MD_TIMEOUT=8). Outputs are
//   packed {pc,FD,DX enables, FD_flush, DX_insert_nop, XM_insert_nop,
//   ctrl_MULT, ctrl_DIV, md_result_select, md_exception, md_timeout}.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] FD_Latch_Instr, DX_Latch_Instr;
    logic        branch_taken, md_resultRDY, md_exception_in;
    logic        pc_enable, FD_enable, DX_enable, FD_flush, DX_insert_nop, XM_insert_nop;
    logic        ctrl_MULT, ctrl_DIV, md_result_select, md_exception, md_timeout;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_stall_controller #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .FD_Latch_Instr   (FD_Latch_Instr),
        .DX_Latch_Instr   (DX_Latch_Instr),
        .branch_taken     (branch_taken),
        .md_resultRDY     (md_resultRDY),
        .md_exception_in  (md_exception_in),
        .pc_enable        (pc_enable),
        .FD_enable        (FD_enable),
        .DX_enable        (DX_enable),
        .FD_flush         (FD_flush),
        .DX_insert_nop    (DX_insert_nop),
        .XM_insert_nop    (XM_insert_nop),
        .ctrl_MULT        (ctrl_MULT),
        .ctrl_DIV         (ctrl_DIV),
        .md_result_select (md_result_select),
        .md_exception     (md_exception),
        .md_timeout       (md_timeout)
    );

    always #5 clock = ~clock;

    logic [10:0] outs;
    assign outs = {pc_enable, FD_enable, DX_enable, FD_flush, DX_insert_nop, XM_insert_nop,
                   ctrl_MULT, ctrl_DIV, md_result_select, md_exception, md_timeout};

    // Expected output patterns
    localparam logic [10:0] RUN        = 11'b111_00_0_00_000;
    localparam logic [10:0] RUN_TO     = 11'b111_00_0_00_001;
    localparam logic [10:0] FREEZE     = 11'b000_00_1_00_000;
    localparam logic [10:0] FREEZE_TO  = 11'b000_00_1_00_001;
    localparam logic [10:0] FREEZE_MUL = 11'b000_00_1_10_000;
    localparam logic [10:0] FREEZE_DIV = 11'b000_00_1_01_000;
    localparam logic [10:0] LU         = 11'b001_01_0_00_000;
    localparam logic [10:0] BR         = 11'b111_11_0_00_000;
    localparam logic [10:0] DONE_OK    = 11'b111_00_0_00_100;
    localparam logic [10:0] DONE_EXC   = 11'b111_00_0_00_110;
    localparam logic [10:0] DONE_TO    = 11'b111_00_0_00_111;

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    logic [31:0] nop_i, lw5_i, add_r5_i, mul_i, div_i;

    task automatic check(input string tag, input logic [10:0] observed, input logic [10:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven after this.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // Load-use case from a clean, bubble-free starting point.
    task automatic lu_case(input string tag, input logic [31:0] fd, input logic [31:0] dx,
                           input logic [10:0] expected);
        FD_Latch_Instr = nop_i;
        DX_Latch_Instr = nop_i;
        cyc();
        cyc();
        FD_Latch_Instr = fd;
        DX_Latch_Instr = dx;
        #1;
        check(tag, outs, expected);
    endtask

    initial begin
        nop_i    = '0;
        lw5_i    = mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0);
        add_r5_i = mk(5'd0, 5'd6, 5'd5, 5'd2, 5'd0);
        mul_i    = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd6);
        div_i    = mk(5'd0, 5'd4, 5'd1, 5'd2, 5'd7);

        // Reset with a mul sitting in DX: outputs must still show reset values.
        reset = 1'b1;
        FD_Latch_Instr = nop_i;
        DX_Latch_Instr = mul_i;
        branch_taken = 1'b0;
        md_resultRDY = 1'b0;
        md_exception_in = 1'b0;
        #3;
        check("reset_outputs", outs, RUN);
        cyc();
        check("reset_hold", outs, RUN);
        DX_Latch_Instr = nop_i;
        reset = 1'b0;
        cyc();
        #1;
        check("idle_after_reset", outs, RUN);

        // 1. lw r5 / add r6,r5,r2: one bubble, then enables return.
        DX_Latch_Instr = lw5_i;
        FD_Latch_Instr = add_r5_i;
        #1;
        check("lu_add_stall", outs, LU);
        cyc();
        #1;
        check("lu_single_bubble", outs, RUN);
        DX_Latch_Instr = nop_i;
        cyc();
        #1;
        check("lu_after_bubble", outs, RUN);

        // Load-use decode per instruction type
        lu_case("lu_addi_rs",   mk(5'd5, 5'd6, 5'd5, 5'd0, 5'd0), lw5_i, LU);
        lu_case("lu_r_rt",      mk(5'd0, 5'd6, 5'd2, 5'd5, 5'd0), lw5_i, LU);
        lu_case("lu_r_rd_only", mk(5'd0, 5'd5, 5'd2, 5'd3, 5'd0), lw5_i, RUN);
        lu_case("lu_sw_rd",     mk(5'd7, 5'd5, 5'd1, 5'd0, 5'd0), lw5_i, LU);
        lu_case("lu_bne_rd",    mk(5'd2, 5'd5, 5'd1, 5'd0, 5'd0), lw5_i, LU);
        lu_case("lu_jr_rd",     mk(5'd4, 5'd5, 5'd0, 5'd0, 5'd0), lw5_i, LU);
        lu_case("lu_addi_rt",   mk(5'd5, 5'd6, 5'd1, 5'd5, 5'd0), lw5_i, RUN);
        lu_case("lu_j_none",    mk(5'd1, 5'd5, 5'd5, 5'd5, 5'd0), lw5_i, RUN);
        lu_case("lu_r0_dest",   mk(5'd0, 5'd6, 5'd0, 5'd0, 5'd0),
                mk(5'd8, 5'd0, 5'd1, 5'd0, 5'd0), RUN);
        lu_case("lu_bex_r30",   mk(5'd22, 5'd0, 5'd0, 5'd0, 5'd0),
                mk(5'd8, 5'd30, 5'd1, 5'd0, 5'd0), LU);
        lu_case("lu_not_load",  add_r5_i, mk(5'd5, 5'd5, 5'd1, 5'd0, 5'd0), RUN);

        // 2. mul, RDY on the 5th BUSY cycle
        FD_Latch_Instr = nop_i;
        DX_Latch_Instr = nop_i;
        cyc();
        cyc();
        DX_Latch_Instr = mul_i;
        #1;
        check("mul_detect", outs, FREEZE);
        cyc();
        #1;
        check("mul_busy1", outs, FREEZE_MUL);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            #1;
            check("mul_busy_mid", outs, FREEZE);
        end
        cyc();
        md_resultRDY = 1'b1;
        #1;
        check("mul_busy5_rdy", outs, FREEZE);
        cyc();
        md_resultRDY = 1'b0;
        #1;
        check("mul_done", outs, DONE_OK);
        cyc();
        DX_Latch_Instr = nop_i;
        #1;
        check("mul_no_retrigger", outs, RUN);
        cyc();
        #1;
        check("mul_idle", outs, RUN);

        // 3. div with RDY and exception together
        DX_Latch_Instr = div_i;
        #1;
        check("div_detect", outs, FREEZE);
        cyc();
        #1;
        check("div_busy1", outs, FREEZE_DIV);
        cyc();
        md_resultRDY = 1'b1;
        md_exception_in = 1'b1;
        #1;
        check("div_busy2_rdy", outs, FREEZE);
        cyc();
        md_resultRDY = 1'b0;
        md_exception_in = 1'b0;
        #1;
        check("div_done_exc", outs, DONE_EXC);
        cyc();
        DX_Latch_Instr = nop_i;
        #1;
        check("div_idle", outs, RUN);

        // 4. mul, no RDY: watchdog after 8 BUSY cycles
        cyc();
        DX_Latch_Instr = mul_i;
        #1;
        check("to_detect", outs, FREEZE);
        cyc();
        #1;
        check("to_busy1", outs, FREEZE_MUL);
        for (int i = 2; i <= 8; i++) begin
            cyc();
            #1;
            check("to_busy_mid", outs, FREEZE);
        end
        cyc();
        #1;
        check("to_done", outs, DONE_TO);
        cyc();
        DX_Latch_Instr = nop_i;
        #1;
        check("to_sticky", outs, RUN_TO);

        // RDY on the final watchdog cycle is a normal completion; start clears md_timeout.
        cyc();
        DX_Latch_Instr = mul_i;
        #1;
        check("edge_detect", outs, FREEZE_TO);
        cyc();
        #1;
        check("edge_busy1", outs, FREEZE_MUL);
        for (int i = 2; i <= 7; i++) begin
            cyc();
            #1;
            check("edge_busy_mid", outs, FREEZE);
        end
        cyc();
        md_resultRDY = 1'b1;
        #1;
        check("edge_busy8_rdy", outs, FREEZE);
        cyc();
        md_resultRDY = 1'b0;
        #1;
        check("edge_done_ok", outs, DONE_OK);
        cyc();
        DX_Latch_Instr = nop_i;
        #1;
        check("edge_idle", outs, RUN);

        // 5. branch wins over a pending load-use hazard
        cyc();
        DX_Latch_Instr = lw5_i;
        FD_Latch_Instr = add_r5_i;
        branch_taken = 1'b1;
        #1;
        check("branch_over_lu", outs, BR);
        cyc();
        branch_taken = 1'b0;
        DX_Latch_Instr = nop_i;
        FD_Latch_Instr = nop_i;
        #1;
        check("branch_after", outs, RUN);

        // 6. reset in BUSY cycle 3 of a div
        cyc();
        DX_Latch_Instr = div_i;
        #1;
        check("rst_div_detect", outs, FREEZE);
        cyc();
        #1;
        check("rst_div_busy1", outs, FREEZE_DIV);
        cyc();
        cyc();
        #1;
        check("rst_div_busy3", outs, FREEZE);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", outs, RUN);
        cyc();
        #1;
        check("rst_no_ctrl_div", outs, RUN);
        DX_Latch_Instr = nop_i;
        reset = 1'b0;
        cyc();
        #1;
        check("rst_released_idle", outs, RUN);
        DX_Latch_Instr = mul_i;
        #1;
        check("rst_restart_detect", outs, FREEZE);
        cyc();
        #1;
        check("rst_restart_busy1", outs, FREEZE_MUL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
